lzc_norm_arbiter: RTL

- Shares one 32-bit leading-zero-count and normalize datapath among NREQ requesters.
- Typical requesters are FP conversion, add/sub and log/convertToInteger operators.
- Round-robin arbitration, 2-stage pipeline, valid/ready handshake on every port.
- Each result returns the leading-zero count, the left-normalized operand, an all-zero flag and the requester ID.

---
 rtl/lzc_norm_arbiter_pkg.sv | 28 ++
 rtl/lzc_norm_arbiter_count32.sv | 31 +++
 rtl/lzc_norm_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lzc_norm_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the LZC/normalize arbiter.
package lzc_arb_pkg;

  localparam int LZC_W   = 32;
  localparam int CNT_W   = 6;
  localparam int MAX_REQ = 8;

  // Returns a one-hot vector selecting the first set bit of req, searching
  // upward from ptr and wrapping modulo n. Bits at or above n are ignored.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/lzc_norm_arbiter_count32.sv
// Combinational 32-bit leading-zero counter built from two 16-bit halves.
module lzc_count32
  import lzc_arb_pkg::*;
(
  input  logic [LZC_W-1:0] din,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  logic [4:0] lz_hi;
  logic [4:0] lz_lo;
  logic       hi_zero;
  logic       lo_zero;

  // Per-half priority scan; the highest set bit is visited last and wins.
  always_comb begin
    lz_hi = 5'd16;
    lz_lo = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (din[16+i]) lz_hi = 5'(15 - i);
      if (din[i])    lz_lo = 5'(15 - i);
    end
  end

  assign hi_zero  = (din[31:16] == 16'h0);
  assign lo_zero  = (din[15:0]  == 16'h0);
  assign all_zero = hi_zero & lo_zero;
  // An all-zero operand yields 16 + 16 = 32 through the lower-half path.
  assign count    = hi_zero ? (6'd16 + {1'b0, lz_lo}) : {1'b0, lz_hi};

endmodule

// File: rtl/lzc_norm_arbiter.sv
// Round-robin shared LZC/normalize unit with a two-stage valid/ready pipeline.
module lzc_norm_arbiter
  import lzc_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*LZC_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDW-1:0]        out_id,
  output logic [CNT_W-1:0]      out_count,
  output logic [LZC_W-1:0]      out_norm,
  output logic                  out_zero
);

  logic                s1_valid_q, s1_valid_d;
  logic [IDW-1:0]      s1_id_q,    s1_id_d;
  logic [LZC_W-1:0]    s1_data_q,  s1_data_d;
  logic [IDW-1:0]      ptr_q,      ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [IDW-1:0]      out_id_q,    out_id_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic [LZC_W-1:0]    out_norm_q,  out_norm_d;
  logic                out_zero_q,  out_zero_d;

  logic                adv1, adv2;
  logic [MAX_REQ-1:0]  pick;
  logic [NREQ-1:0]     grant;
  logic [2:0]          gnt_idx;
  logic [LZC_W-1:0]    sel_data;
  logic [CNT_W-1:0]    lzc_cnt;
  logic                lzc_zero;

  lzc_count32 u_lzc (
    .din      (s1_data_q),
    .count    (lzc_cnt),
    .all_zero (lzc_zero)
  );

  // Stall chain, round-robin grant and operand select.
  always_comb begin
    adv2     = ~out_valid_q | out_ready;
    adv1     = ~s1_valid_q | adv2;
    pick     = rr_pick(MAX_REQ'(req_valid), 3'(ptr_q), NREQ);
    grant    = (adv1 && !RESET) ? pick[NREQ-1:0] : '0;
    gnt_idx  = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) gnt_idx = 3'(i);
    end
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) sel_data = req_data[i*LZC_W +: LZC_W];
    end
  end

  assign req_ready = grant;

  // Next-state for both pipeline stages and the round-robin pointer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_data_d   = s1_data_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_count_d = out_count_q;
    out_norm_d  = out_norm_q;
    out_zero_d  = out_zero_q;
    if (adv1) begin
      s1_valid_d = |grant;
      s1_id_d    = IDW'(gnt_idx);
      s1_data_d  = sel_data;
    end
    if (|grant) begin
      ptr_d = (gnt_idx == 3'(NREQ - 1)) ? '0 : IDW'(gnt_idx + 3'd1);
    end
    if (adv2) begin
      out_valid_d = s1_valid_q;
      out_id_d    = s1_id_q;
      out_count_d = lzc_cnt;
      out_zero_d  = lzc_zero;
      out_norm_d  = lzc_zero ? '0 : (s1_data_q << lzc_cnt);
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_data_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_count_q <= '0;
      out_norm_q  <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_data_q   <= s1_data_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_count_q <= out_count_d;
      out_norm_q  <= out_norm_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_count = out_count_q;
  assign out_norm  = out_norm_q;
  assign out_zero  = out_zero_q;

endmodule
